// File: rtl/jam_pkg.sv
// Shared types and constants for the job-assignment cost server.
// Used by jam_cost_server and jam_sweep_monitor.
package jam_pkg;

  localparam int COST_W    = 7;
  localparam int SUM_W     = 10;
  localparam int N_JOBS    = 8;
  localparam int N_ENTRIES = N_JOBS * N_JOBS;

  typedef logic [2:0]        idx_t;
  typedef logic [5:0]        addr_t;
  typedef logic [COST_W-1:0] cost_t;
  typedef logic [SUM_W-1:0]  sum_t;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // One-hot job mask used to track which jobs a sweep has already touched.
  function automatic logic [N_JOBS-1:0] onehot(input idx_t i);
    logic [N_JOBS-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/jam_sweep_monitor.sv
// Sweep monitor: follows W = 0..7 query sweeps, sums the costs and checks
// that the eight job indices were all distinct. Only built when
// JAM_SWEEP_CHECK_EN is defined.
module jam_sweep_monitor
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_active,
  input  logic [2:0]        i_w,
  input  logic [2:0]        i_j,
  input  logic [COST_W-1:0] i_cost,
  output logic              o_done,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_perm_ok
);

  logic              r_busy;
  idx_t              r_expect;
  sum_t              r_acc;
  logic [N_JOBS-1:0] r_used;
  logic              r_flag;
  logic              r_done;
  sum_t              r_sum;
  logic              r_perm_ok;

  logic [N_JOBS-1:0] w_j_mask;
  sum_t              w_acc_add;
  logic              w_flag_add;
  logic              w_hit;

  // Combinational step values for the in-order continuation of a sweep.
  always_comb begin
    w_j_mask   = onehot(i_j);
    w_acc_add  = r_acc + sum_t'(i_cost);
    w_flag_add = r_flag & ~(|(r_used & w_j_mask));
    w_hit      = r_busy && (i_w == r_expect);
  end

  // Sweep tracking: W=0 (re)starts, the expected W advances, anything else aborts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy    <= 1'b0;
      r_expect  <= '0;
      r_acc     <= '0;
      r_used    <= '0;
      r_flag    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_perm_ok <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_active) begin
        r_busy <= 1'b0;
      end else if (i_w == 3'd0) begin
        r_busy   <= 1'b1;
        r_acc    <= sum_t'(i_cost);
        r_used   <= w_j_mask;
        r_flag   <= 1'b1;
        r_expect <= 3'd1;
      end else if (w_hit) begin
        r_acc  <= w_acc_add;
        r_used <= r_used | w_j_mask;
        r_flag <= w_flag_add;
        if (r_expect == 3'd7) begin
          // Completed sweep; go idle so a held W=7 cannot retrigger.
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_sum     <= w_acc_add;
          r_perm_ok <= w_flag_add;
        end else begin
          r_expect <= r_expect + 3'd1;
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done    = r_done;
  assign o_sum     = r_sum;
  assign o_perm_ok = r_perm_ok;

endmodule

// File: rtl/jam_cost_server.sv
// Job-assignment cost server: loads an 8x8 cost table through a
// valid/ready stream, then answers (W, J) queries with a registered cost
// one cycle later. Optional sweep monitor enabled by JAM_SWEEP_CHECK_EN.
module jam_cost_server
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  input  logic              reload,
  output logic              table_ready,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              sweep_done,
  output logic [SUM_W-1:0]  sweep_cost,
  output logic              sweep_perm_ok
);

  state_t r_state;
  addr_t  r_idx;
  logic   r_load_ready;
  cost_t  r_cost;
  cost_t  r_table [0:N_ENTRIES-1];

  state_t w_state_next;
  addr_t  w_idx_next;
  logic   w_load_ready_next;
  logic   w_accept;
  cost_t  w_cost_next;
  cost_t  w_rd_cost;

  // Row-major table address: worker in the upper bits, job in the lower.
  assign w_rd_cost = r_table[{W, J}];

  // Next-state logic: load 64 entries, then serve until reload.
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_load_ready_next = r_load_ready;
    w_accept          = 1'b0;
    w_cost_next       = '0;
    case (r_state)
      ST_LOAD: begin
        w_load_ready_next = 1'b1;
        w_accept          = load_valid && r_load_ready;
        if (w_accept) begin
          if (r_idx == addr_t'(N_ENTRIES - 1)) begin
            w_state_next      = ST_SERVE;
            w_idx_next        = '0;
            w_load_ready_next = 1'b0;
          end else begin
            w_idx_next = r_idx + addr_t'(1);
          end
        end
      end
      ST_SERVE: begin
        w_load_ready_next = 1'b0;
        if (reload) begin
          // Reload takes priority: the query this cycle is dropped.
          w_state_next      = ST_LOAD;
          w_idx_next        = '0;
          w_load_ready_next = 1'b1;
        end else begin
          w_cost_next = w_rd_cost;
        end
      end
      default: begin
        w_state_next = ST_LOAD;
        w_idx_next   = '0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_LOAD;
      r_idx        <= '0;
      r_load_ready <= 1'b0;
      r_cost       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_load_ready <= w_load_ready_next;
      r_cost       <= w_cost_next;
    end
  end

  // Table storage; contents survive reset and are simply overwritten on load.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_table[r_idx] <= load_data;
    end
  end

  assign load_ready  = r_load_ready;
  assign table_ready = (r_state == ST_SERVE);
  assign Cost        = r_cost;

`ifdef JAM_SWEEP_CHECK_EN
  logic w_serve_active;
  assign w_serve_active = (r_state == ST_SERVE) && !reload;

  jam_sweep_monitor u_sweep_monitor (
    .CLK       (CLK),
    .RST       (RST),
    .i_active  (w_serve_active),
    .i_w       (W),
    .i_j       (J),
    .i_cost    (w_rd_cost),
    .o_done    (sweep_done),
    .o_sum     (sweep_cost),
    .o_perm_ok (sweep_perm_ok)
  );
`else
  assign sweep_done    = 1'b0;
  assign sweep_cost    = '0;
  assign sweep_perm_ok = 1'b0;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server: table load, query latency, reload,
// mid-load reset and (when JAM_SWEEP_CHECK_EN is defined) sweep monitoring.
module tb_jam_cost_server;

  logic       CLK;
  logic       RST;
  logic       load_valid;
  logic [6:0] load_data;
  logic       load_ready;
  logic       reload;
  logic       table_ready;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       sweep_done;
  logic [9:0] sweep_cost;
  logic       sweep_perm_ok;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] w;
    logic [2:0] j;
    logic [6:0] exp_cost;
  } qvec_t;

  qvec_t vecs [8];

  jam_cost_server dut (
    .CLK          (CLK),
    .RST          (RST),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .reload       (reload),
    .table_ready  (table_ready),
    .W            (W),
    .J            (J),
    .Cost         (Cost),
    .sweep_done   (sweep_done),
    .sweep_cost   (sweep_cost),
    .sweep_perm_ok(sweep_perm_ok)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stream n entries; pattern 0 = 10*worker+job, pattern 1 = all ones.
  task automatic load_table(input int pattern, input int n, input bit toggle);
    int k;
    int cyc;
    bit acc;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 500) begin
      @(negedge CLK);
      if (k == 63) check("table_ready_before_last", table_ready, 0);
      load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      load_data  = (pattern == 0) ? 7'(10 * (k / 8) + (k % 8)) : 7'd1;
      acc        = load_valid && load_ready;
      @(posedge CLK);
      if (acc) k++;
      cyc++;
    end
    if (k < n) check("load_timeout", k, n);
    @(negedge CLK);
    load_valid = 1'b0;
    $display("load pattern=%0d accepts=%0d cycles=%0d", pattern, k, cyc);
  endtask

  // Drive n (W,J) pairs back to back (packed 3 bits each, index 0 at LSB),
  // then hold the last pair; count sweep_done pulses and capture the result.
  task automatic run_seq(input int n, input logic [23:0] ws, input logic [23:0] js,
                         output int ndone, output logic [9:0] cost, output logic perm);
    ndone = 0;
    cost  = '0;
    perm  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i > 0 && sweep_done) ndone++;
      W = ws[3*i +: 3];
      J = js[3*i +: 3];
    end
    for (int h = 0; h < 2; h++) begin
      @(negedge CLK);
      if (sweep_done) begin
        ndone++;
        cost = sweep_cost;
        perm = sweep_perm_ok;
      end
    end
    $display("sweep n=%0d done=%0d cost=%0d perm_ok=%0d", n, ndone, cost, perm);
  endtask

  task automatic query_one(input string name, input logic [2:0] w, input logic [2:0] j,
                           input logic [6:0] exp);
    @(negedge CLK);
    W = w;
    J = j;
    @(negedge CLK);
    $display("query W=%0d J=%0d cost=%0d", w, j, Cost);
    check(name, Cost, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    logic [9:0] sc;
    logic pk;

    vecs[0] = '{3'd3, 3'd5, 7'd35};
    vecs[1] = '{3'd0, 3'd0, 7'd0};
    vecs[2] = '{3'd7, 3'd7, 7'd77};
    vecs[3] = '{3'd2, 3'd1, 7'd21};
    vecs[4] = '{3'd6, 3'd4, 7'd64};
    vecs[5] = '{3'd1, 3'd7, 7'd17};
    vecs[6] = '{3'd5, 3'd0, 7'd50};
    vecs[7] = '{3'd4, 3'd6, 7'd46};

    RST        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    reload     = 1'b0;
    W          = '0;
    J          = '0;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check("rst_load_ready", load_ready, 0);
    check("rst_table_ready", table_ready, 0);
    check("rst_cost", Cost, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_sweep_cost", sweep_cost, 0);
    check("rst_sweep_perm_ok", sweep_perm_ok, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_load_ready", load_ready, 1);
    check("post_rst_table_ready", table_ready, 0);

    // Continuous load of 10*w+j
    load_table(0, 64, 1'b0);
    check("load_table_ready", table_ready, 1);
    check("load_load_ready", load_ready, 0);

    // Back-to-back query vectors
    W = vecs[0].w;
    J = vecs[0].j;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      $display("query W=%0d J=%0d cost=%0d", vecs[i].w, vecs[i].j, Cost);
      check($sformatf("cost_vec%0d", i), Cost, vecs[i].exp_cost);
      if (i < 7) begin
        W = vecs[i+1].w;
        J = vecs[i+1].j;
      end
    end

    // Sweeps
    run_seq(8, 24'o76543210, 24'o76543210, nd, sc, pk);
`ifdef JAM_SWEEP_CHECK_EN
    check("sweep_diag_count", nd, 1);
    check("sweep_diag_cost", sc, 308);
    check("sweep_diag_perm", pk, 1);
`else
    check("sweep_tied_count", nd, 0);
    check("sweep_tied_cost", sweep_cost, 0);
`endif
    run_seq(8, 24'o76543210, 24'o66543210, nd, sc, pk);
`ifdef JAM_SWEEP_CHECK_EN
    check("sweep_dup_count", nd, 1);
    check("sweep_dup_cost", sc, 307);
    check("sweep_dup_perm", pk, 0);
`else
    check("sweep_tied_perm", sweep_perm_ok, 0);
`endif
    run_seq(4, 24'o5210, 24'o5210, nd, sc, pk);
    check("sweep_abort_count", nd, 0);
`ifdef JAM_SWEEP_CHECK_EN
    check("sweep_abort_held_cost", sweep_cost, 307);
`endif

    // Reload mid-sweep
    @(negedge CLK);
    W = 3'd0; J = 3'd0;
    @(negedge CLK);
    W = 3'd1; J = 3'd1;
    @(negedge CLK);
    W = 3'd2; J = 3'd2;
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
    check("reload_table_ready", table_ready, 0);
    check("reload_cost", Cost, 0);
    check("reload_load_ready", load_ready, 1);
    check("reload_sweep_done", sweep_done, 0);
`ifdef JAM_SWEEP_CHECK_EN
    check("reload_keeps_cost", sweep_cost, 307);
    check("reload_keeps_perm", sweep_perm_ok, 0);
`endif

    // All-ones table
    load_table(1, 64, 1'b0);
    check("ones_table_ready", table_ready, 1);
    query_one("ones_cost_3_5", 3'd3, 3'd5, 7'd1);
    run_seq(8, 24'o76543210, 24'o76543210, nd, sc, pk);
`ifdef JAM_SWEEP_CHECK_EN
    check("ones_sweep_count", nd, 1);
    check("ones_sweep_cost", sc, 8);
    check("ones_sweep_perm", pk, 1);
`endif

    // Back to LOAD, partial load, then reset mid-load
    @(negedge CLK);
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
    check("reload2_table_ready", table_ready, 0);
    load_table(0, 30, 1'b0);
    check("partial_table_ready", table_ready, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_load_ready", load_ready, 0);
    check("midrst_table_ready", table_ready, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_post_load_ready", load_ready, 1);

    // Toggling-valid load must still need a full 64 accepts
    load_table(0, 64, 1'b1);
    check("toggle_table_ready", table_ready, 1);
    check("toggle_load_ready", load_ready, 0);
    query_one("toggle_cost_2_1", 3'd2, 3'd1, 7'd21);
    query_one("toggle_cost_7_7", 3'd7, 3'd7, 7'd77);
    query_one("toggle_cost_0_3", 3'd0, 3'd3, 7'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder end of the job-assignment cost interface.
- Holds the 8x8 worker/job cost table, loaded once through a valid/ready stream.
- Answers every (W, J) query with the registered Cost one cycle later, the timing the assignment engine accumulates against.
- Optional sweep monitor checks each full W=0..7 query sweep: total cost and job uniqueness.

Parameters:
- COST_W, 7, width of one cost entry and of Cost.
- SUM_W, 10, width of the sweep cost sum; holds 8*(2^COST_W-1).
- N, 8, workers and jobs; fixed at 8, with 3-bit index fields.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; synchronous, active-high.
- load_valid  input  1  load entry present.
- load_data  input  COST_W  cost entry; row-major order: entry k = worker k[5:3], job k[2:0].
- load_ready  output  1  table accepting entries.
- reload  input  1  pulse in SERVE: discard table, return to LOAD.
- table_ready  output  1  table complete, queries valid.
- W  input  3  queried worker index.
- J  input  3  queried job index.
- Cost  output  COST_W  registered cost[W][J].
- sweep_done  output  1  one-cycle pulse at the end of a sweep.
- sweep_cost  output  SUM_W  sum of the 8 sweep costs; held until the next sweep_done.
- sweep_perm_ok  output  1  the 8 J values of the sweep were distinct; held.

Behaviour:
- Reset values: all outputs 0, state LOAD, load index 0, load_ready 1 on the cycle after reset deasserts. Table contents are not reset.
- States and transitions:
  - LOAD -> SERVE: on the 64th accepted entry.
  - SERVE -> LOAD: on reload.
  - No other transitions.
- LOAD:
  - load_ready = 1.
  - An entry is accepted when load_valid && load_ready; it writes table[idx], then idx increments.
  - On idx = 63 accept: the next cycle has state SERVE, table_ready = 1, load_ready = 0, idx = 0.
  - load_valid while load_ready = 0 is ignored.
- SERVE:
  - Every cycle, Cost <= table[W][J]. Latency is exactly 1 cycle; there is no handshake on queries.
  - Changing W/J every cycle yields a new Cost every cycle.
- Reload:
  - Same cycle: reload wins over all other SERVE activity.
  - Next cycle: LOAD, table_ready = 0, idx = 0, Cost = 0.
  - reload in LOAD is ignored.
- Cost in LOAD is 0.
- Query sampled at the cycle of table_ready rising: does not occur; queries count from the first SERVE cycle.
- RST mid-load discards the progress; no partial table is marked ready.

Optional Feature:
- Macro: JAM_SWEEP_CHECK_EN.
- With the macro, sweep monitor, active only in SERVE:
  - A sweep starts or restarts whenever W = 0: acc = table[0][J], used = one-hot(J), expect = 1.
  - If W == expect (1..7): acc += table[W][J], perm flag cleared if used[J] is already set, used |= one-hot(J), expect++.
  - W = 7 accepted: the next cycle sweep_done = 1, sweep_cost = acc + table[7][J], sweep_perm_ok = flag. Aligned with the Cost for W = 7. The monitor then idles until W = 0.
  - Any W other than 0 or expect aborts silently (no sweep_done).
  - W held at 7 after completion does not retrigger.
  - Reload aborts the sweep but keeps sweep_cost and sweep_perm_ok.
- Without the macro: sweep_done, sweep_cost and sweep_perm_ok are tied to 0; no monitor registers.

Decomposition:
- Package jam_pkg holds:
  - COST_W, SUM_W, N_JOBS = 8.
  - The state enum (ST_LOAD, ST_SERVE).
  - The index typedef (3 bits) and the cost typedef.
- One sub-module: jam_sweep_monitor (accumulator, used-mask, expect counter). It is instantiated only under JAM_SWEEP_CHECK_EN and reads the table through a combinational port.

Test Plan:
- Reset, then load 64 entries with cost = 10*worker + job, load_valid continuous -> table_ready rises the cycle after the 64th accept; load_ready falls.
- Query (W=3, J=5) -> Cost = 35 one cycle later; back-to-back (0,0), (7,7) -> 0 then 77 on consecutive cycles.
- Load with load_valid toggling every other cycle -> still exactly 64 accepts; the entry for (2,1) reads 21.
- Sweep with J = W for W = 0..7 -> sweep_done once, sweep_cost = 0+11+22+33+44+55+66+77 = 308, sweep_perm_ok = 1.
- Sweep with J = 0,1,2,3,4,5,6,6 -> sweep_cost = 0+11+22+33+44+55+66+76 = 307, sweep_perm_ok = 0.
- Sweep W = 0,1,2,5 -> no sweep_done.
- reload pulse mid-sweep -> table_ready = 0 and Cost = 0 next cycle; reload a table of all 1s -> full sweep gives sweep_cost = 8.
- RST after 30 entries -> LOAD with idx 0, table_ready stays 0 until 64 new accepts.
